// File: rtl/comp_share_arb_if.sv
// Requester-side bundle for comp_share_arb: request handshake with packed operands,
// and per-requester response handshake with the shared result and requester index.
interface comp_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN     = 16,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*LEN-1:0] req_in1;
  logic [NUM_REQ*LEN-1:0] req_in2;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic                   rsp_result;
  logic [ID_W-1:0]        rsp_id;

  // Requester cluster side
  modport master (
    output req_valid,
    output req_in1,
    output req_in2,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_id
  );

  // Arbiter side
  modport slave (
    input  req_valid,
    input  req_in1,
    input  req_in2,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_result,
    output rsp_id
  );
endinterface

// File: rtl/comp_share_arb.sv
// Round-robin arbiter time-sharing one signed comparator among NUM_REQ requesters:
// grant in IDLE, drive the comparator for one CMP cycle, hold the result in RESP.
module comp_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int LEN     = 16,
  parameter int ID_W    = 2
) (
  input  logic            clk,
  input  logic            rstn,
  comp_share_arb_if.slave bus,
  output logic [LEN-1:0]  cmp_in1,
  output logic [LEN-1:0]  cmp_in2,
  input  logic            cmp_out,
  output logic            busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic [ID_W-1:0] ptr_reg, ptr_next;
  logic [ID_W-1:0] id_reg, id_next;
  logic [LEN-1:0]  op1_reg, op1_next;
  logic [LEN-1:0]  op2_reg, op2_next;
  logic            result_reg, result_next;

  logic [LEN-1:0]     in1_arr [NUM_REQ];
  logic [LEN-1:0]     in2_arr [NUM_REQ];
  logic [NUM_REQ-1:0] above_mask;

  logic            hi_found, any_found;
  logic [ID_W-1:0] hi_idx, any_idx;
  logic            win_valid;
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] win_succ;

  // Unpack operands and flag requesters at or above the round-robin pointer
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign in1_arr[gi]    = bus.req_in1[gi*LEN +: LEN];
      assign in2_arr[gi]    = bus.req_in2[gi*LEN +: LEN];
      assign above_mask[gi] = bus.req_valid[gi] && (ID_W'(gi) >= ptr_reg);
    end
  endgenerate

  // Two-level priority: lowest valid index at or above ptr, else lowest valid overall.
  always_comb begin
    hi_found  = 1'b0;
    hi_idx    = '0;
    any_found = 1'b0;
    any_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (above_mask[i]) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(i);
      end
      if (bus.req_valid[i]) begin
        any_found = 1'b1;
        any_idx   = ID_W'(i);
      end
    end
  end

  assign win_valid = any_found;
  assign win_idx   = hi_found ? hi_idx : any_idx;
  assign win_succ  = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    id_next     = id_reg;
    op1_next    = op1_reg;
    op2_next    = op2_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          state_next = CMP;
          op1_next   = in1_arr[win_idx];
          op2_next   = in2_arr[win_idx];
          id_next    = win_idx;
          ptr_next   = win_succ;
        end
      end
      CMP: begin
        result_next = cmp_out;
        state_next  = RESP;
      end
      RESP: begin
        // Only the answered requester's accept matters
        if (bus.rsp_ready[id_reg]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      id_reg     <= '0;
      op1_reg    <= '0;
      op2_reg    <= '0;
      result_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      id_reg     <= id_next;
      op1_reg    <= op1_next;
      op2_reg    <= op2_next;
      result_reg <= result_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_hs
      assign bus.req_ready[gi] = (state_reg == IDLE) && win_valid && (win_idx == ID_W'(gi));
      assign bus.rsp_valid[gi] = (state_reg == RESP) && (id_reg == ID_W'(gi));
    end
  endgenerate

  // Comparator inputs held at zero outside CMP to keep it quiet
  assign cmp_in1        = (state_reg == CMP) ? op1_reg : '0;
  assign cmp_in2        = (state_reg == CMP) ? op2_reg : '0;
  assign bus.rsp_result = result_reg;
  assign bus.rsp_id     = id_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_comp_share_arb.sv
// Directed bench for comp_share_arb with a transaction-level model checked every cycle
// plus literal expectations for the scenarios of interest.
module tb_comp_share_arb;
  localparam int NUM_REQ = 4;
  localparam int LEN     = 9;
  localparam int ID_W    = 2;

  logic           clk = 1'b0;
  logic           rstn;
  logic [LEN-1:0] cmp_in1, cmp_in2;
  logic           cmp_out;
  logic           busy;

  comp_share_arb_if #(.NUM_REQ(NUM_REQ), .LEN(LEN), .ID_W(ID_W)) bus ();

  comp_share_arb #(.NUM_REQ(NUM_REQ), .LEN(LEN), .ID_W(ID_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .cmp_in1 (cmp_in1),
    .cmp_in2 (cmp_in2),
    .cmp_out (cmp_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Shared comparator: signed greater-than
  assign cmp_out = $signed(cmp_in1) > $signed(cmp_in2);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Model: one outstanding transaction, either comparing or responding
  bit                    t_active, t_resp, m_res;
  int                    t_id, m_ptr;
  logic signed [LEN-1:0] t_a, t_b;
  bit                    n_active, n_resp, n_res;
  int                    n_id, n_ptr;
  logic signed [LEN-1:0] n_a, n_b;

  logic [NUM_REQ-1:0] rdy_snap = '0;
  logic [NUM_REQ-1:0] keep_mask = '0;
  int                 grants[$];

  always @(negedge clk) begin : model_cmp
    logic [NUM_REQ-1:0] e_rdy, e_rspv;
    logic [LEN-1:0]     e_c1, e_c2;
    int                 win;
    if (!rstn) begin
      n_active = 0; n_resp = 0; n_res = 0; n_id = 0; n_ptr = 0; n_a = '0; n_b = '0;
      rdy_snap = '0;
    end else begin
      win = -1;
      if (!t_active) begin
        for (int j = NUM_REQ - 1; j >= 0; j--)
          if (bus.req_valid[j] && j >= m_ptr) win = j;
        if (win < 0)
          for (int j = NUM_REQ - 1; j >= 0; j--)
            if (bus.req_valid[j]) win = j;
      end
      e_rdy = '0;
      if (win >= 0) e_rdy[win] = 1'b1;
      e_rspv = '0;
      if (t_active && t_resp) e_rspv[t_id] = 1'b1;
      e_c1 = (t_active && !t_resp) ? t_a : '0;
      e_c2 = (t_active && !t_resp) ? t_b : '0;
      chk("m_req_ready", bus.req_ready, e_rdy);
      chk("m_rsp_valid", bus.rsp_valid, e_rspv);
      chk("m_cmp_in1", cmp_in1, e_c1);
      chk("m_cmp_in2", cmp_in2, e_c2);
      chk("m_busy", busy, t_active);
      if (t_active && t_resp) begin
        chk("m_rsp_id", bus.rsp_id, t_id);
        chk("m_rsp_result", bus.rsp_result, m_res);
      end
      rdy_snap = bus.req_ready;
      for (int j = 0; j < NUM_REQ; j++)
        if (bus.req_ready[j]) grants.push_back(j);
      n_active = t_active; n_resp = t_resp; n_res = m_res;
      n_id = t_id; n_ptr = m_ptr; n_a = t_a; n_b = t_b;
      if (win >= 0) begin
        n_active = 1; n_resp = 0; n_id = win;
        n_a = bus.req_in1[win*LEN +: LEN];
        n_b = bus.req_in2[win*LEN +: LEN];
        n_ptr = (win + 1) % NUM_REQ;
      end else if (t_active && !t_resp) begin
        n_resp = 1;
        n_res  = (t_a > t_b);
      end else if (t_active && t_resp && bus.rsp_ready[t_id]) begin
        n_active = 0;
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_active <= 0; t_resp <= 0; m_res <= 0; t_id <= 0; m_ptr <= 0; t_a <= '0; t_b <= '0;
    end else begin
      t_active <= n_active; t_resp <= n_resp; m_res <= n_res;
      t_id <= n_id; m_ptr <= n_ptr; t_a <= n_a; t_b <= n_b;
    end
  end

  // Advance one cycle; granted requesters drop valid unless kept asserted
  task automatic tick();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~(rdy_snap & ~keep_mask);
  endtask

  task automatic put(input int i, input int a, input int b);
    bus.req_valid[i] = 1'b1;
    bus.req_in1[i*LEN +: LEN] = LEN'(a);
    bus.req_in2[i*LEN +: LEN] = LEN'(b);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && busy; k++) tick();
    chk("drain_busy", busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_result"}, bus.rsp_result, 0);
    chk({tag, "_rsp_id"}, bus.rsp_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmp_in1"}, cmp_in1, 0);
    chk({tag, "_cmp_in2"}, cmp_in2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.req_valid = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rstn = 1'b1;
    bus.rsp_ready = '1;
    tick();

    // Single request from 2: -100 > 88 is false
    put(2, -100, 88);
    #1;
    chk("s1_req_ready", bus.req_ready, 4'b0100);
    tick();
    chk("s1_cmp_in1", cmp_in1, 9'h19C);
    chk("s1_cmp_in2", cmp_in2, 9'h058);
    tick();
    chk("s1_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("s1_rsp_id", bus.rsp_id, 2);
    chk("s1_rsp_result", bus.rsp_result, 0);
    tick();
    chk("s1_idle", busy, 0);

    // 121 > -5 is true; operands disturbed during CMP must not matter
    put(2, 121, -5);
    #1;
    chk("s2_req_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_in1[2*LEN +: LEN] = LEN'(-200);
    #1;
    chk("s2_cmp_in1", cmp_in1, 9'h079);
    chk("s2_cmp_in2", cmp_in2, 9'h1FB);
    tick();
    chk("s2_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("s2_rsp_result", bus.rsp_result, 1);
    tick();

    // Backpressure on requester 1 while 3 waits
    bus.rsp_ready = 4'b1101;
    put(1, -3, -7);
    tick();
    put(3, 5, 6);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 4'b0010);
      chk("bp_rsp_result", bus.rsp_result, 1);
      chk("bp_req_ready", bus.req_ready, 0);
      tick();
    end
    bus.rsp_ready = 4'b1111;
    #1;
    chk("bp_still_valid", bus.rsp_valid, 4'b0010);
    tick();
    chk("bp_next_grant", bus.req_ready, 4'b1000);
    tick();
    tick();
    chk("bp_r3_result", bus.rsp_result, 0);
    chk("bp_r3_id", bus.rsp_id, 3);
    drain();

    // Pointer wrap: 3 alone, then 0 and 3 together
    put(3, 10, 20);
    #1;
    chk("pw_r3_grant", bus.req_ready, 4'b1000);
    tick();
    drain();
    put(0, 7, 7);
    put(3, 1, 0);
    bus.rsp_ready = 4'b0100;
    #1;
    chk("pw_r0_wins", bus.req_ready, 4'b0001);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("pw_wrong_ready", bus.rsp_valid, 4'b0001);
      chk("pw_r0_result", bus.rsp_result, 0);
      tick();
    end
    bus.rsp_ready = 4'b0001;
    tick();
    chk("pw_r3_after", bus.req_ready, 4'b1000);
    bus.rsp_ready = '1;
    tick();
    drain();

    // Asynchronous reset mid-response
    put(2, 50, -50);
    bus.rsp_ready = '0;
    tick();
    tick();
    chk("ar_in_resp", bus.rsp_valid, 4'b0100);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_vals("ar");
    @(posedge clk);
    #1;
    grants.delete();
    keep_mask = '1;
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    rstn = 1'b1;
    #1;
    chk("ar_first_grant", bus.req_ready, 4'b0001);

    // Full load fairness
    repeat (24) tick();
    chk("rr_count_ok", grants.size() >= 8, 1);
    if (grants.size() >= 8) begin
      for (int k = 0; k < 8; k++) chk("rr_order", grants[k], k % NUM_REQ);
    end
    keep_mask = '0;
    bus.req_valid = '0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
